// File: rtl/botao_condicionador.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, toggle level and press pulse.
// Optional auto-repeat while held is enabled by defining AUTOREPEAT_EN.
//
// state        | meaning
// SOLTO        | button released and stable, estavel=0
// CONFIRMA_P   | s2 went high, counting stable cycles before accepting the press
// PRESSIONADO  | button pressed and stable, estavel=1
// CONFIRMA_S   | s2 went low, counting stable cycles before accepting the release
module botao_condicionador #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned REPEAT_CYCLES   = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic botao_raw,
  output logic botao,
  output logic estavel,
  output logic pulso
);

  typedef enum logic [1:0] {
    SOLTO       = 2'd0,
    CONFIRMA_P  = 2'd1,
    PRESSIONADO = 2'd2,
    CONFIRMA_S  = 2'd3
  } state_t;

  state_t           state_q;
  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             botao_q;
  logic             estavel_q;
  logic             pulso_q;
  logic             cnt_last;

  assign cnt_last = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

`ifdef AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);
  logic [REP_W-1:0] rep_q;
  logic             rep_last;
  assign rep_last = (rep_q == REP_W'(REPEAT_CYCLES - 1));
`else
  localparam int unsigned UNUSED_REPEAT = REPEAT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SOLTO;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      botao_q   <= 1'b0;
      estavel_q <= 1'b0;
      pulso_q   <= 1'b0;
`ifdef AUTOREPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      s1_q    <= botao_raw;
      s2_q    <= s1_q;
      pulso_q <= 1'b0;
      case (state_q)
        SOLTO: begin
          estavel_q <= 1'b0;
          if (s2_q) begin
            state_q <= CONFIRMA_P;
            cnt_q   <= '0;
          end
        end
        CONFIRMA_P: begin
          if (!s2_q) begin
            state_q <= SOLTO;
            cnt_q   <= '0;
          end else if (cnt_last) begin
            state_q   <= PRESSIONADO;
            cnt_q     <= '0;
            estavel_q <= 1'b1;
            botao_q   <= ~botao_q;
            pulso_q   <= 1'b1;
`ifdef AUTOREPEAT_EN
            rep_q     <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESSIONADO: begin
          estavel_q <= 1'b1;
          if (!s2_q) begin
            state_q <= CONFIRMA_S;
            cnt_q   <= '0;
`ifdef AUTOREPEAT_EN
            rep_q   <= '0;
`endif
          end
`ifdef AUTOREPEAT_EN
          // Held button: wrap the repeat counter and emit another press.
          else if (rep_last) begin
            rep_q   <= '0;
            pulso_q <= 1'b1;
            botao_q <= ~botao_q;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
`endif
        end
        CONFIRMA_S: begin
          if (s2_q) begin
            state_q <= PRESSIONADO;
            cnt_q   <= '0;
`ifdef AUTOREPEAT_EN
            rep_q   <= '0;
`endif
          end else if (cnt_last) begin
            state_q   <= SOLTO;
            cnt_q     <= '0;
            estavel_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= SOLTO;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign botao   = botao_q;
  assign estavel = estavel_q;
  assign pulso   = pulso_q;

endmodule

// File: tb/tb_botao_condicionador.sv
// Directed bench for botao_condicionador with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Expectations for the held-button phase follow AUTOREPEAT_EN when it is defined.
module tb_botao_condicionador;

  localparam int DEB = 4;
  localparam int REP = 8;
`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic raw   = 1'b0;
  logic botao;
  logic estavel;
  logic pulso;

  int total = 0;
  int bad   = 0;
  int np;

  botao_condicionador #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .botao_raw(raw),
    .botao(botao),
    .estavel(estavel),
    .pulso(pulso)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_count(input int n, inout int cnt);
    for (int i = 0; i < n; i++) begin
      step();
      cnt += int'(pulso);
    end
  endtask

  initial begin
    // Asynchronous reset with raw high, no clock edge yet
    #1;
    rst_n = 1'b0;
    raw   = 1'b1;
    #1;
    chk("rst_async_botao", botao, 0);
    chk("rst_async_estavel", estavel, 0);
    chk("rst_async_pulso", pulso, 0);
    step();
    step();
    chk("rst_held_estavel", estavel, 0);
    rst_n = 1'b1;

    // Press after reset release: accepted on edge 7
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("t1_wait_estavel", estavel, 0);
      chk("t1_wait_pulso", pulso, 0);
    end
    step();
    chk("t1_e7_pulso", pulso, 1);
    chk("t1_e7_botao", botao, 1);
    chk("t1_e7_estavel", estavel, 1);
    step();
    chk("t1_e8_pulso", pulso, 0);
    chk("t1_e8_botao", botao, 1);
    step();
    step();

    // Release: estavel drops on edge 7, no pulse, botao kept
    raw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("t2_rel_wait_estavel", estavel, 1);
      chk("t2_rel_wait_pulso", pulso, 0);
    end
    step();
    chk("t2_rel_estavel", estavel, 0);
    chk("t2_rel_botao", botao, 1);
    chk("t2_rel_pulso", pulso, 0);
    step();

    // Bounce 1,0,1,0 at two cycles each, then held high
    np = 0;
    for (int k = 0; k < 4; k++) begin
      raw = (k % 2 == 0);
      run_count(2, np);
    end
    chk("t3_bounce_pulses", np, 0);
    chk("t3_bounce_estavel", estavel, 0);
    raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("t3_wait_pulso", pulso, 0);
    end
    step();
    chk("t3_e7_pulso", pulso, 1);
    chk("t3_e7_botao", botao, 0);
    chk("t3_e7_estavel", estavel, 1);
    raw = 1'b0;
    repeat (8) step();
    chk("t3_rel_estavel", estavel, 0);

    // Two clean presses
    np = 0;
    raw = 1'b1;
    run_count(10, np);
    chk("t4_press1_botao", botao, 1);
    raw = 1'b0;
    run_count(10, np);
    raw = 1'b1;
    run_count(10, np);
    chk("t4_press2_botao", botao, 0);
    raw = 1'b0;
    run_count(10, np);
    chk("t4_pulses", np, 2);

    // Reset in the middle of a press confirmation
    raw = 1'b1;
    repeat (10) step();
    raw = 1'b0;
    repeat (10) step();
    chk("t5_pre_botao", botao, 1);
    raw = 1'b1;
    repeat (5) step();
    chk("t5_confirm_estavel", estavel, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_botao", botao, 0);
    chk("t5_rst_estavel", estavel, 0);
    chk("t5_rst_pulso", pulso, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("t5_wait_pulso", pulso, 0);
      chk("t5_wait_estavel", estavel, 0);
    end
    step();
    chk("t5_e7_pulso", pulso, 1);
    chk("t5_e7_botao", botao, 1);
    chk("t5_e7_estavel", estavel, 1);

    // Keep holding 30 cycles past the accepted press
    np = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      np += int'(pulso);
      chk("t6_hold_pulso", pulso, (AR && (k % REP == 0)) ? 1 : 0);
    end
    chk("t6_extra_pulses", np, AR ? 3 : 0);
    chk("t6_botao", botao, AR ? 0 : 1);
    chk("t6_estavel", estavel, 1);
    raw = 1'b0;
    repeat (8) step();
    chk("t6_rel_estavel", estavel, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
